alu_arbiter: RTL and testbench

Shares one combinational 4-bit ALU (operands A/B, 3-bit select, 4-bit result) between up to NUM_REQ requesters. Round-robin arbitration, a valid/ready request handshake and a held response with backpressure. Sits between requesting datapath blocks and the ALU instance. It latches the granted operands, drives the ALU ports, captures the result and returns it tagged with the requester index.

---
 rtl/alu_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NUM_REQ requesters.
// Round-robin grant in IDLE, a single execute cycle, then a held response
// until the consumer takes it. Operands are latched at grant time and
// driven to the ALU from registers. The ALU result is captured at the end of
// the execute cycle and returned tagged with the index of its requester.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int SEL_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [SEL_W-1:0]           alu_sel,
    input  logic [WIDTH-1:0]           alu_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_result,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       busy,
    output logic [7:0]                 ops_done
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [WIDTH-1:0]  op_a_reg;
    logic [WIDTH-1:0]  op_b_reg;
    logic [SEL_W-1:0]  op_sel_reg;
    logic [WIDTH-1:0]  rsp_result_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [7:0]        ops_done_reg;

    logic              grant_fire;
    logic              rsp_fire;

    // ------------------------------------------------------------------
    // Unpack the flat request buses into per-requester slices.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  a_slice   [NUM_REQ];
    logic [WIDTH-1:0]  b_slice   [NUM_REQ];
    logic [SEL_W-1:0]  sel_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_slice[gi]   = req_a[gi*WIDTH +: WIDTH];
            assign b_slice[gi]   = req_b[gi*WIDTH +: WIDTH];
            assign sel_slice[gi] = req_sel[gi*SEL_W +: SEL_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search. Candidate gi is the requester at distance gi
    // from rr_ptr, wrapped by subtraction so that a non-power-of-two
    // NUM_REQ never produces an out-of-range index.
    // ------------------------------------------------------------------
    logic [ID_W:0]        ptr_sum  [NUM_REQ];
    logic [ID_W-1:0]      cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_hit;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_any;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign ptr_sum[gi]  = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
            assign cand_idx[gi] = (ptr_sum[gi] >= (ID_W+1)'(NUM_REQ))
                                ? ID_W'(ptr_sum[gi] - (ID_W+1)'(NUM_REQ))
                                : ID_W'(ptr_sum[gi]);
            assign cand_hit[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    // Pick the nearest valid candidate; scanning from the far end lets the
    // closest hit overwrite any farther one.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant_idx = cand_idx[k];
                grant_any = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Controller.
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and the Mealy accept strobe. The strobe is suppressed while
    // rst_n is low: a handshake on a reset edge would be silently dropped.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        grant_fire = 1'b0;
        rsp_fire   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rst_n && grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    grant_fire           = 1'b1;
                    state_next           = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath.
    // ------------------------------------------------------------------

    // Operand registers double as the ALU port drivers, so the ALU sees the
    // granted operands throughout EXEC and keeps them in IDLE and RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            op_sel_reg <= '0;
        end else if (grant_fire) begin
            op_a_reg   <= a_slice[grant_idx];
            op_b_reg   <= b_slice[grant_idx];
            op_sel_reg <= sel_slice[grant_idx];
        end
    end

    // Response tag is taken at grant; result is sampled at the end of EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_id_reg     <= '0;
            rsp_result_reg <= '0;
        end else begin
            if (grant_fire) begin
                rsp_id_reg <= grant_idx;
            end
            if (state_reg == EXEC) begin
                rsp_result_reg <= alu_result;
            end
        end
    end

    // Fairness pointer and completion counter move only on a taken response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg   <= '0;
            ops_done_reg <= '0;
        end else if (rsp_fire) begin
            if ({1'b0, rsp_id_reg} + (ID_W+1)'(1) >= (ID_W+1)'(NUM_REQ)) begin
                rr_ptr_reg <= '0;
            end else begin
                rr_ptr_reg <= rsp_id_reg + ID_W'(1);
            end
            ops_done_reg <= ops_done_reg + 8'd1;
        end
    end

    assign alu_a      = op_a_reg;
    assign alu_b      = op_b_reg;
    assign alu_sel    = op_sel_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_valid  = (state_reg == RESP);
    assign busy       = (state_reg != IDLE);
    assign ops_done   = ops_done_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a response scoreboard.
// The bench supplies the ALU itself and predicts each response from the
// operands it drove.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [11:0] req_sel;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [3:0]  alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_result;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [7:0]  ops_done;

    logic [3:0]  tb_a   [4];
    logic [3:0]  tb_b   [4];
    logic [2:0]  tb_sel [4];

    typedef struct {
        int         id;
        logic [3:0] res;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          fail_cnt  = 0;
    logic [7:0]  exp_ops   = 8'd0;

    alu_arbiter #(.NUM_REQ(4), .WIDTH(4), .SEL_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] s);
        case (s)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_sel);
    assign req_a      = {tb_a[3], tb_a[2], tb_a[1], tb_a[0]};
    assign req_b      = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};
    assign req_sel    = {tb_sel[3], tb_sel[2], tb_sel[1], tb_sel[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Pop the oldest expectation and compare it with the presented response.
    task automatic check_rsp(output exp_t e);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'(sb.size()), 32'd1);
            e = '{-1, 4'h0};
        end else begin
            e = sb.pop_front();
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            $display("[TB] rsp id=%0d result=%b (expected id=%0d result=%b) ops_done=%0d",
                     rsp_id, rsp_result, e.id, e.res, ops_done);
        end
    endtask

    // Current cycle is IDLE with inputs settled; requester id must win.
    task automatic grant_check(input int id);
        check("grant", 32'(req_ready), 32'(1 << id));
        check("busy_idle", 32'(busy), 32'd0);
        sb.push_back('{id, alu_model(tb_a[id], tb_b[id], tb_sel[id])});
    endtask

    // Full transaction with rsp_ready high; ends settled in the next IDLE cycle.
    task automatic run_txn(input int id, input bit keep);
        exp_t e;
        grant_check(id);
        tick();
        if (!keep) req_valid = 4'b0000;
        settle();
        check("exec_no_ready", 32'(req_ready), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_no_rsp", 32'(rsp_valid), 32'd0);
        check("alu_a", 32'(alu_a), 32'(tb_a[id]));
        check("alu_b", 32'(alu_b), 32'(tb_b[id]));
        check("alu_sel", 32'(alu_sel), 32'(tb_sel[id]));
        tick();
        settle();
        check_rsp(e);
        check("resp_no_ready", 32'(req_ready), 32'd0);
        tick();
        settle();
        exp_ops = exp_ops + 8'd1;
        check("rsp_dropped", 32'(rsp_valid), 32'd0);
        check("ops_done", 32'(ops_done), 32'(exp_ops));
    endtask

    initial begin
        exp_t held;

        tb_a[0] = 4'b0011; tb_b[0] = 4'b0001; tb_sel[0] = 3'b000;
        tb_a[1] = 4'b0111; tb_b[1] = 4'b0010; tb_sel[1] = 3'b001;
        tb_a[2] = 4'b1100; tb_b[2] = 4'b1010; tb_sel[2] = 3'b010;
        tb_a[3] = 4'b0101; tb_b[3] = 4'b0110; tb_sel[3] = 3'b101;
        rsp_ready = 1'b1;

        // Reset held two cycles with every requester asking.
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        tick();
        tick();
        settle();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        tick();

        // Reset during EXEC aborts the transaction.
        req_valid = 4'b1000;
        settle();
        grant_check(3);
        tick();
        req_valid = 4'b0000;
        settle();
        check("midop_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        settle();
        check("midop_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midop_busy_rst", 32'(busy), 32'd0);
        check("midop_ops_done", 32'(ops_done), 32'(exp_ops));
        check("midop_alu_a", 32'(alu_a), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            check("midop_no_rsp", 32'(rsp_valid), 32'd0);
            check("midop_idle", 32'(busy), 32'd0);
        end

        // Single request from requester 0: 3 + 1 = 4.
        req_valid = 4'b0001;
        settle();
        run_txn(0, 1'b0);
        check("single_result", 32'(rsp_result), 32'b0100);
        check("single_ops", 32'(ops_done), 32'd1);

        // Reset pulse returns the pointer and counter to zero.
        rst_n = 1'b0;
        tick();
        settle();
        exp_ops = 8'd0;
        check("pulse_ops_done", 32'(ops_done), 32'd0);
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        settle();

        // Round-robin with every requester valid continuously.
        run_txn(0, 1'b1);
        run_txn(1, 1'b1);
        run_txn(2, 1'b1);
        check("rr_req2_result", 32'(rsp_result), 32'b1000);
        run_txn(3, 1'b1);
        run_txn(0, 1'b0);

        // Backpressure: requesters 0 and 2 valid, pointer at 1 -> grant 2.
        req_valid = 4'b0101;
        settle();
        grant_check(2);
        tick();
        rsp_ready = 1'b0;
        settle();
        check("bp_exec_no_ready", 32'(req_ready), 32'd0);
        tick();
        settle();
        check_rsp(held);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", 32'(rsp_result), 32'(held.res));
            check("bp_rsp_id", 32'(rsp_id), 32'd2);
            check("bp_no_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        settle();
        tick();
        settle();
        exp_ops = exp_ops + 8'd1;
        check("bp_released", 32'(rsp_valid), 32'd0);
        check("bp_ops_done", 32'(ops_done), 32'(exp_ops));
        run_txn(0, 1'b0);

        // Counter wrap: reset, then 256 subtractions 4 - 1 = 3 on requester 1.
        rst_n = 1'b0;
        tick();
        settle();
        exp_ops = 8'd0;
        rst_n     = 1'b1;
        tb_a[1]   = 4'b0100;
        tb_b[1]   = 4'b0001;
        tb_sel[1] = 3'b001;
        for (int n = 1; n <= 256; n++) begin
            req_valid = 4'b0010;
            settle();
            run_txn(1, 1'b0);
            check("wrap_result", 32'(rsp_result), 32'b0011);
            if (n == 255) check("wrap_ops_255", 32'(ops_done), 32'd255);
        end
        check("wrap_ops_zero", 32'(ops_done), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
